// File: rtl/pcseq_pkg.sv
// Shared types and helpers for the multi-hart PC sequencer.
// The optional PC_ALIGN_CHECK_EN macro is consumed by pc_sequencer.
package pcseq_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int REQ_PC_W   = 32;
  localparam int REQ_HART_W = 8;

  typedef struct packed {
    logic [REQ_PC_W-1:0]   pc;
    logic [REQ_HART_W-1:0] hart;
  } fetch_req_t;

  function automatic int hart_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pc_sequencer_rr_pick.sv
// Combinational round-robin selector: first enabled index after last,
// searched cyclically.
module rr_pick #(
  parameter int N  = 2,
  parameter int HW = 1
) (
  input  logic [N-1:0]  en_in,
  input  logic [HW-1:0] last_in,
  output logic          any_out,
  output logic [HW-1:0] idx_out
);

  logic w_found;

  always_comb begin
    w_found = 1'b0;
    idx_out = '0;
    any_out = |en_in;
    for (int k = 1; k <= N; k++) begin
      if (!w_found && en_in[(int'(last_in) + k) % N]) begin
        w_found = 1'b1;
        idx_out = HW'((int'(last_in) + k) % N);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-hart PC sequencer: per-hart PCs, round-robin issue, redirects.
// Define PC_ALIGN_CHECK_EN to reject misaligned redirects.
module pc_sequencer
  import pcseq_pkg::*;
#(
  parameter int                WIDTH        = 32,
  parameter int                NUM_HARTS    = 2,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int                INC          = 4,
  localparam int               HART_W       = hart_w(NUM_HARTS)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 stall_in,
  input  logic [NUM_HARTS-1:0] hart_en_in,
  input  logic                 redirect_valid_in,
  input  logic [HART_W-1:0]    redirect_hart_in,
  input  logic [WIDTH-1:0]     redirect_pc_in,
  output logic                 fetch_valid_out,
  input  logic                 fetch_ready_in,
  output logic [WIDTH-1:0]     fetch_pc_out,
  output logic [HART_W-1:0]    fetch_hart_out,
  output logic                 misalign_out
);

  localparam logic [HART_W:0]   NH       = (HART_W+1)'(NUM_HARTS);
  localparam logic [HART_W-1:0] LAST_RST = HART_W'(NUM_HARTS - 1);

  typedef struct packed {
    logic [WIDTH-1:0]  pc;
    logic [HART_W-1:0] hart;
  } slot_t;

  slot_state_e       r_state;
  slot_state_e       w_state_nxt;
  slot_t             r_slot;
  logic [WIDTH-1:0]  r_pc [NUM_HARTS];
  logic [HART_W-1:0] r_last;
  logic [HART_W-1:0] w_sel;
  logic [WIDTH-1:0]  w_sel_pc;
  logic [WIDTH-1:0]  w_redir_pc;
  logic              w_any;
  logic              w_hart_ok;
  logic              w_redir_ok;
  logic              w_accept;
  logic              w_load;
  logic              w_kill;

  rr_pick #(
    .N  (NUM_HARTS),
    .HW (HART_W)
  ) u_rr_pick (
    .en_in   (hart_en_in),
    .last_in (r_last),
    .any_out (w_any),
    .idx_out (w_sel)
  );

  assign w_hart_ok = {1'b0, redirect_hart_in} < NH;

`ifdef PC_ALIGN_CHECK_EN
  logic r_misalign;

  assign w_redir_ok = redirect_valid_in && w_hart_ok
                   && (redirect_pc_in[1:0] == 2'b00);
  assign w_redir_pc = redirect_pc_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= redirect_valid_in && w_hart_ok
                 && (redirect_pc_in[1:0] != 2'b00);
    end
  end

  assign misalign_out = r_misalign;
`else
  logic w_unused_lo;

  assign w_redir_ok   = redirect_valid_in && w_hart_ok;
  assign w_redir_pc   = {redirect_pc_in[WIDTH-1:2], 2'b00};
  assign w_unused_lo  = ^redirect_pc_in[1:0];
  assign misalign_out = 1'b0;
`endif

  assign w_accept = (r_state == SLOT_FULL) && fetch_ready_in;

  // Any redirect strobe, even a rejected one, suppresses loading.
  assign w_load = ((r_state == SLOT_EMPTY) || w_accept)
               && !stall_in && !redirect_valid_in && w_any;

  assign w_kill = w_redir_ok && (r_state == SLOT_FULL)
               && (r_slot.hart == redirect_hart_in) && !w_accept;

  always_comb begin
    w_sel_pc = r_pc[0];
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (w_sel == HART_W'(h)) w_sel_pc = r_pc[h];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SLOT_EMPTY: begin
        if (w_load) w_state_nxt = SLOT_FULL;
      end
      SLOT_FULL: begin
        if (w_load)                 w_state_nxt = SLOT_FULL;
        else if (w_accept || w_kill) w_state_nxt = SLOT_EMPTY;
      end
      default: w_state_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= SLOT_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_slot <= '0;
      r_last <= LAST_RST;
    end else if (w_load) begin
      r_slot <= '{pc: w_sel_pc, hart: w_sel};
      r_last <= w_sel;
    end
  end

  // Redirect wins over the issue increment for the same hart.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int h = 0; h < NUM_HARTS; h++) r_pc[h] <= RESET_VECTOR;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (w_redir_ok && (redirect_hart_in == HART_W'(h))) begin
          r_pc[h] <= w_redir_pc;
        end else if (w_load && (w_sel == HART_W'(h))) begin
          r_pc[h] <= r_pc[h] + WIDTH'(INC);
        end
      end
    end
  end

  assign fetch_valid_out = (r_state == SLOT_FULL);
  assign fetch_pc_out    = r_slot.pc;
  assign fetch_hart_out  = r_slot.hart;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (NUM_HARTS=2, INC=4).
// Accepted requests are popped from a queue of expected {hart, pc}.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [1:0]  en;
  logic        rv;
  logic        rh;
  logic [31:0] rpc;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic        hart;
  logic        mis;

  int errors = 0;
  int checks = 0;

  logic [32:0] q[$];

  pc_sequencer dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .stall_in          (stall),
    .hart_en_in        (en),
    .redirect_valid_in (rv),
    .redirect_hart_in  (rh),
    .redirect_pc_in    (rpc),
    .fetch_valid_out   (valid),
    .fetch_ready_in    (ready),
    .fetch_pc_out      (pc),
    .fetch_hart_out    (hart),
    .misalign_out      (mis)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got hart=%0d pc=%h, none expected",
                 hart, pc);
      end else begin
        logic [32:0] e;
        e = q.pop_front();
        if ({hart, pc} !== e) begin
          errors++;
          $display("FAIL sb_accept got hart=%0d pc=%h need hart=%0d pc=%h",
                   hart, pc, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; en = 2'b11;
    rv = 1'b0; rh = 1'b0; rpc = '0; ready = 1'b0;
    tick(); tick();
    checks++;
    if ({valid, pc, hart, mis} !== 35'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b pc=%h h=%b m=%b need all 0",
               valid, pc, hart, mis);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL first_valid got %b need 1", valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({valid, pc, hart} !== 34'd0) begin
      errors++;
      $display("FAIL async_reset got v=%b pc=%h h=%b need 0",
               valid, pc, hart);
    end
  endtask

  task automatic test_issue;
    tick();
    q.push_back({1'b0, 32'h0});
    q.push_back({1'b1, 32'h0});
    q.push_back({1'b0, 32'h4});
    q.push_back({1'b1, 32'h4});
    ready = 1'b1;
    rst = 1'b0;
    repeat (5) tick();
    ready = 1'b0;
    checks++;
    if ({valid, hart, pc} !== {1'b1, 1'b0, 32'h8}) begin
      errors++;
      $display("FAIL issue_next got v=%b h=%b pc=%h need v=1 h=0 pc=8",
               valid, hart, pc);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({valid, hart, pc} !== {1'b1, 1'b0, 32'h8}) begin
        errors++;
        $display("FAIL hold_%0d got v=%b h=%b pc=%h need v=1 h=0 pc=8",
                 i, valid, hart, pc);
      end
    end
    q.push_back({1'b0, 32'h8});
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if ({valid, hart, pc} !== {1'b1, 1'b1, 32'h8}) begin
      errors++;
      $display("FAIL bp_release got v=%b h=%b pc=%h need v=1 h=1 pc=8",
               valid, hart, pc);
    end
  endtask

  task automatic test_redirect_kill;
    rv = 1'b1; rh = 1'b1; rpc = 32'h100;
    tick();
    rv = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL kill got valid=%b need 0", valid);
    end
    tick();
    q.push_back({1'b0, 32'hC});
    q.push_back({1'b1, 32'h100});
    q.push_back({1'b0, 32'h10});
    q.push_back({1'b1, 32'h104});
    ready = 1'b1;
    repeat (4) tick();
    ready = 1'b0;
  endtask

  task automatic test_redirect_accept;
    rv = 1'b1; rh = 1'b0; rpc = 32'h200;
    ready = 1'b1;
    q.push_back({1'b0, 32'h14});
    tick();
    rv = 1'b0;
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_noload got valid=%b need 0", valid);
    end
    tick();
    checks++;
    if ({valid, hart, pc} !== {1'b1, 1'b1, 32'h108}) begin
      errors++;
      $display("FAIL redir_next got v=%b h=%b pc=%h need v=1 h=1 pc=108",
               valid, hart, pc);
    end
    q.push_back({1'b1, 32'h108});
    q.push_back({1'b0, 32'h200});
    ready = 1'b1;
    tick();
    checks++;
    if ({hart, pc} !== {1'b0, 32'h200}) begin
      errors++;
      $display("FAIL redir_pc got h=%b pc=%h need h=0 pc=200", hart, pc);
    end
    tick();
    ready = 1'b0;
  endtask

  task automatic test_stall_enable;
    stall = 1'b1;
    ready = 1'b1;
    q.push_back({1'b1, 32'h10C});
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d got valid=%b need 0", i, valid);
      end
      tick();
    end
    stall = 1'b0;
    q.push_back({1'b0, 32'h204});
    q.push_back({1'b1, 32'h110});
    q.push_back({1'b1, 32'h114});
    q.push_back({1'b1, 32'h118});
    tick();
    tick();
    en = 2'b10;
    tick(); tick(); tick();
    ready = 1'b0;
    checks++;
    if ({valid, hart, pc} !== {1'b1, 1'b1, 32'h11C}) begin
      errors++;
      $display("FAIL en_only1 got v=%b h=%b pc=%h need v=1 h=1 pc=11c",
               valid, hart, pc);
    end
    en = 2'b00;
    ready = 1'b1;
    q.push_back({1'b1, 32'h11C});
    tick();
    tick();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL no_harts got valid=%b need 0", valid);
    end
    ready = 1'b0;
    rv = 1'b1; rh = 1'b1; rpc = 32'hFFFF_FFFC;
    tick();
    rv = 1'b0;
    en = 2'b10;
    ready = 1'b1;
    q.push_back({1'b1, 32'hFFFF_FFFC});
    q.push_back({1'b1, 32'h0});
    tick(); tick(); tick();
    ready = 1'b0;
    en = 2'b11;
    checks++;
    if ({valid, hart, pc} !== {1'b1, 1'b1, 32'h4}) begin
      errors++;
      $display("FAIL wrap got v=%b h=%b pc=%h need v=1 h=1 pc=4",
               valid, hart, pc);
    end
  endtask

  task automatic test_alignment;
    logic [31:0] exp_pc;
    logic        exp_mis;
`ifdef PC_ALIGN_CHECK_EN
    exp_pc  = 32'h208;
    exp_mis = 1'b1;
`else
    exp_pc  = 32'h100;
    exp_mis = 1'b0;
`endif
    rv = 1'b1; rh = 1'b0; rpc = 32'h102;
    tick();
    rv = 1'b0;
    checks++;
    if (mis !== exp_mis) begin
      errors++;
      $display("FAIL misalign_pulse got %b need %b", mis, exp_mis);
    end
    q.push_back({1'b1, 32'h4});
    q.push_back({1'b0, exp_pc});
    ready = 1'b1;
    tick();
    checks++;
    if ({hart, pc} !== {1'b0, exp_pc}) begin
      errors++;
      $display("FAIL align_pc got h=%b pc=%h need h=0 pc=%h",
               hart, pc, exp_pc);
    end
    tick();
    ready = 1'b0;
    checks++;
    if (mis !== 1'b0) begin
      errors++;
      $display("FAIL misalign_clear got %b need 0", mis);
    end
  endtask

  initial begin
    test_reset();
    test_issue();
    test_backpressure();
    test_redirect_kill();
    test_redirect_accept();
    test_stall_enable();
    test_alignment();
    tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending need 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-hart program-counter sequencer: the parametrised successor to the single-PC stall register. It holds one PC per hart, picks harts round-robin and issues fetch requests over a valid/ready handshake, and applies per-hart redirects from execute. It sits at the head of the fetch stage, and drives fetch address and hart ID into the I-cache/IMEM port.

## Interface
- WIDTH, 32, PC width in bits.
- NUM_HARTS, 2, number of hardware threads (≥1).
- RESET_VECTOR, 32'h0000_0000, reset PC of every hart.
- INC, 4, sequential PC increment.
- HART_W, derived max(1,$clog2(NUM_HARTS)), hart-ID width (localparam).

- clk_in  input  1  clock, all state on rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- stall_in  input  1  blocks loading of new requests.
- hart_en_in  input  NUM_HARTS  per-hart issue enable.
- redirect_valid_in  input  1  redirect strobe, one cycle.
- redirect_hart_in  input  HART_W  hart being redirected.
- redirect_pc_in  input  WIDTH  new PC for that hart.
- fetch_valid_out  output  1  request slot holds a valid request.
- fetch_ready_in  input  1  consumer accepts request this cycle.
- fetch_pc_out  output  WIDTH  request PC.
- fetch_hart_out  output  HART_W  request hart ID.
- misalign_out  output  1  one-cycle pulse, rejected redirect (macro only; tied 0 otherwise).

## Operation
- State: pc[h] = next PC to issue per hart; one output slot (EMPTY/FULL FSM); rr pointer last = last hart issued.
- Reset: pc[h]=RESET_VECTOR, slot EMPTY, last=NUM_HARTS-1 (first pick is hart 0), fetch_valid_out=0, fetch_pc_out=0, fetch_hart_out=0, misalign_out=0.
- Accept = fetch_valid_out && fetch_ready_in. Accept moves FULL→EMPTY unless a load happens the same edge.
- Load condition: (slot EMPTY or accept) && !stall_in && no redirect this cycle && some enabled hart exists. Selected hart s = first enabled hart after last, searched cyclically. Load does slot←{pc[s], s}, pc[s]←pc[s]+INC (mod 2^WIDTH), last←s, and the slot becomes FULL.
- Hold rule: while FULL and not accepted, fetch_pc_out/fetch_hart_out stay stable. The request leaves the slot only through an accept or a kill. stall_in never withdraws a valid request.
- Redirect (hart r): pc[r]←redirect_pc_in. This overrides any increment of pc[r] that edge. If the slot holds hart r and is not accepted this cycle, the slot is killed (EMPTY). If it is accepted the same cycle, the transfer counts and the consumer discards it. No load occurs in a redirect cycle. redirect_hart_in ≥ NUM_HARTS is ignored.
- hart_en_in deasserted for a hart with its request in the slot: the request stays until accepted. It affects selection only.
- No enabled harts: slot drains and stays EMPTY. pc[] is unchanged.
- Stall during EMPTY: no issue. Redirects still apply during a stall.

## Timing
- First request: fetch_valid_out=1 after the first rising edge following reset release (with stall_in=0 and hart 0 enabled).
- Throughput: one request per cycle with ready held high. Load and accept happen on the same edge.
- Redirect latency: redirected PC appears on fetch_pc_out 2 edges after the redirect edge (redirect edge, then load edge).
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- PC_ALIGN_CHECK_EN defined: a redirect with redirect_pc_in[1:0]≠0 is rejected. In that case pc[] and the slot are untouched, misalign_out pulses 1 on the next cycle, and loading is still blocked that cycle.
- Undefined: redirect_pc_in[1:0] is forced to 0 before it is stored, and misalign_out is constant 0.

## Structure
- pcseq_pkg: slot_state_e enum {SLOT_EMPTY, SLOT_FULL}, function hart_w(n) returning max(1,$clog2(n)), and a fetch_req_t struct {pc, hart}.
- Sub-module rr_pick: combinational round-robin selector (inputs: enable vector and last pointer; outputs: any and idx). It is reusable by the later issue arbiter.
- Top level owns the pc[] array, the slot and the rr pointer.

## Test plan
- Reset and issue: assert rst_in mid-run with valid=1 → outputs drop to 0 immediately. Release with NUM_HARTS=2, ready=1 → pc/hart sequence 0/0, 0/1, 4/0, 4/1.
- Backpressure: ready=0 for 3 cycles with valid=1 → fetch_pc_out/fetch_hart_out unchanged. Then ready=1 → next hart issued on the following edge.
- Redirect kill: slot holds hart 1 (pc 0x8), ready=0, redirect hart1→0x100 → valid drops next cycle. The next hart-1 request carries 0x100 and its following one 0x104.
- Redirect plus accept, same hart: the accept counts, pc[h] becomes the redirect value (not +4), and no load occurs that cycle.
- Stall and enables: stall_in=1 with slot EMPTY → valid stays 0 and pc[] is unchanged. hart_en_in=2'b10 → only hart 1 is issued. Wrap: pc=0xFFFF_FFFC issues, next is 0x0.
- Alignment: redirect to 0x102. With PC_ALIGN_CHECK_EN, misalign_out pulses and the PC stream is unchanged. Without it, the next hart request is 0x100.
